// File: rtl/odd_parity_pkg.sv
// odd_parity_pkg: shared types and parity helper for the odd-parity serial link
package odd_parity_pkg;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    localparam int MAX_DATA_W = 32;
    localparam int BIT_CNT_W = $clog2(MAX_DATA_W + 1);
    function automatic logic odd_parity_ok(input logic [MAX_DATA_W-1:0] data, input logic p);
        return ^{data, p};
    endfunction
endpackage

// File: rtl/odd_parity_check.sv
// odd_parity_check: combinational odd-parity checker, ok=1 when data+parity hold an odd number of ones
module odd_parity_check import odd_parity_pkg::*; #(
    parameter int W = 8
) (
    input  logic [W-1:0] data,
    input  logic         p,
    output logic         ok
);
    assign ok = odd_parity_ok(MAX_DATA_W'(data), p);
endmodule

// File: rtl/odd_parity_serial_receiver.sv
// odd_parity_serial_receiver: strobe-timed deserialiser with odd-parity, framing and error-count status
module odd_parity_serial_receiver import odd_parity_pkg::*; #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              rx,
    input  logic              clr_count,
    output logic              busy,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic [CNT_W-1:0]  err_count
);
    state_t                 state;
    logic [BIT_CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]      shreg;
    logic                   par_bit;
    logic                   ok;

    odd_parity_check #(.W(DATA_W)) u_check (
        .data (shreg),
        .p    (par_bit),
        .ok   (ok)
    );

    assign busy = state != IDLE;

    // Frame FSM: every transition and capture is gated by the bit strobe; results register on the stop bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (bit_en) begin
                case (state)
                    IDLE: begin
                        if (!rx) begin
                            state <= DATA;
                            cnt   <= '0;
                        end
                    end
                    DATA: begin
                        shreg <= (shreg >> 1) | (DATA_W'(rx) << (DATA_W - 1));
                        cnt   <= cnt + 1'b1;
                        if (cnt == BIT_CNT_W'(DATA_W - 1)) state <= PARITY;
                    end
                    PARITY: begin
                        par_bit <= rx;
                        state   <= STOP;
                    end
                    STOP: begin
                        state      <= IDLE;
                        data_out   <= shreg;
                        parity_err <= ~ok;
                        frame_err  <= ~rx;
                        data_valid <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Saturating count of bad frames; a clear beats a same-edge increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_count <= '0;
        else if (clr_count) err_count <= '0;
        else if (bit_en && state == STOP && (!ok || !rx) && err_count != '1) err_count <= err_count + 1'b1;
    end
endmodule

// File: tb/tb_odd_parity_serial_receiver.sv
// tb_odd_parity_serial_receiver: directed and random frames checked against a frame-level reference model
module tb_odd_parity_serial_receiver;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_en = 1'b0;
    logic       rx = 1'b1;
    logic       clr_count = 1'b0;
    logic       busy8, busy2, dv8, dv2, pe8, pe2, fe8, fe2;
    logic [7:0] do8, do2;
    logic [7:0] ec8;
    logic [1:0] ec2;
    int         errors = 0;
    int         checks = 0;
    int         vcount = 0;
    int         nframes = 0;
    int         m8 = 0;
    int         m2 = 0;

    always #5 clk = ~clk;

    odd_parity_serial_receiver #(.DATA_W(8), .CNT_W(8)) u8 (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .rx(rx), .clr_count(clr_count),
        .busy(busy8), .data_out(do8), .data_valid(dv8), .parity_err(pe8),
        .frame_err(fe8), .err_count(ec8)
    );

    odd_parity_serial_receiver #(.DATA_W(8), .CNT_W(2)) u2 (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .rx(rx), .clr_count(clr_count),
        .busy(busy2), .data_out(do2), .data_valid(dv2), .parity_err(pe2),
        .frame_err(fe2), .err_count(ec2)
    );

    // Counts data_valid pulses, one per high cycle
    always @(negedge clk) if (dv8) vcount++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int gap, input logic clr);
        rx = b;
        bit_en = 1'b0;
        repeat (gap - 1) @(negedge clk);
        bit_en = 1'b1;
        clr_count = clr;
        @(negedge clk);
        bit_en = 1'b0;
        clr_count = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop, input int gap, input logic clr);
        bit pe, fe;
        send_bit(1'b0, gap, 1'b0);
        chk("busy_mid", busy8, 1);
        for (int i = 0; i < 8; i++) send_bit(d[i], gap, 1'b0);
        send_bit(p, gap, 1'b0);
        send_bit(stop, gap, clr);
        #1;
        pe = (($countones(d) + int'(p)) % 2) == 0;
        fe = !stop;
        nframes++;
        if (clr) begin
            m8 = 0;
            m2 = 0;
        end else if (pe || fe) begin
            m8 = (m8 < 255) ? m8 + 1 : 255;
            m2 = (m2 < 3) ? m2 + 1 : 3;
        end
        chk("valid_pulses", vcount, nframes);
        chk("data_valid", dv8, 1);
        chk("data_out", do8, d);
        chk("parity_err", pe8, pe);
        chk("frame_err", fe8, fe);
        chk("err_count8", ec8, m8);
        chk("err_count2", ec2, m2);
        chk("data_out2", do2, d);
        chk("busy_end", busy8, 0);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_data_out"}, do8, 0);
        chk({tag, "_valid"}, dv8, 0);
        chk({tag, "_parity"}, pe8, 0);
        chk({tag, "_frame"}, fe8, 0);
        chk({tag, "_count"}, ec8, 0);
        chk({tag, "_busy"}, busy8, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_cleared("reset");
        rst_n = 1'b1;
        @(negedge clk);
        // clean 0xA5 frame, strobe every 4th cycle
        send_frame(8'hA5, 1'b1, 1'b1, 4, 1'b0);
        @(negedge clk);
        chk("valid_drop", dv8, 0);
        // parity error then a clean frame
        send_frame(8'h07, 1'b1, 1'b1, 4, 1'b0);
        send_frame(8'h07, 1'b0, 1'b1, 4, 1'b0);
        // framing error
        send_frame(8'h3C, 1'b1, 1'b0, 4, 1'b0);
        // reset part-way through a frame
        send_bit(1'b0, 2, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 2, 1'b0);
        #2 rst_n = 1'b0;
        #2;
        check_cleared("abort");
        chk("abort_valid_count", vcount, nframes);
        chk("abort_count2", ec2, 0);
        m8 = 0;
        m2 = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(8'h5A, 1'b1, 1'b1, 3, 1'b0);
        // saturation of the narrow counter, then clear on a bad stop edge
        clr_count = 1'b1;
        @(negedge clk);
        clr_count = 1'b0;
        m8 = 0;
        m2 = 0;
        chk("clr_only8", ec8, 0);
        chk("clr_only2", ec2, 0);
        for (int i = 0; i < 5; i++) send_frame(8'h03, 1'b0, 1'b1, 2, 1'b0);
        send_frame(8'h03, 1'b0, 1'b1, 2, 1'b1);
        // back-to-back frames with strobe gaps of 1 and 7
        send_frame(8'h01, 1'b0, 1'b1, 1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b1, 1, 1'b0);
        send_frame(8'h01, 1'b0, 1'b1, 7, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b1, 7, 1'b0);
        // random frames
        for (int n = 0; n < 30; n++) begin
            logic [7:0] d;
            d = 8'($urandom);
            send_frame(d, 1'($urandom), ($urandom % 5) != 0, int'($urandom_range(1, 4)), ($urandom % 8) == 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/odd_parity_serial_receiver.md
Name: odd_parity_serial_receiver

Overview:
Receive end of the odd-parity link. It deserialises a framed serial stream and checks the odd parity bit that the transmit side generates.
- Frame format: start bit (0), DATA_W data bits LSB first, one odd-parity bit, stop bit (1).
- The block delivers the data word with parity and framing status.
- It keeps a saturating error counter for link-health monitoring.
- Bit timing comes from an external strobe, so the block is baud-agnostic.

Parameters:
DATA_W, 8, number of data bits per frame (1..32)
CNT_W, 8, width of saturating error counter (>=1)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous assert, active-low
bit_en  input  1  one-cycle strobe marking the sample point of the current bit; rx is ignored when low
rx  input  1  serial line; idles high
clr_count  input  1  synchronous clear of err_count
busy  output  1  high while a frame is in progress (state != IDLE)
data_out  output  DATA_W  last received data word
data_valid  output  1  one-cycle pulse when a frame completes
parity_err  output  1  parity status of last frame; 1 = even count of ones over data+parity
frame_err  output  1  stop-bit status of last frame; 1 = stop bit sampled as 0
err_count  output  CNT_W  number of frames with parity_err or frame_err, saturating

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, bit counter=0, shift register=0.
  - data_out=0, data_valid=0, parity_err=0, frame_err=0, err_count=0, busy=0.
  - Reset mid-frame discards the partial frame, and no data_valid is produced.
- States: IDLE, DATA, PARITY, STOP. All transitions occur only on edges where bit_en=1; with bit_en=0 every state holds.
- IDLE:
  - bit_en & rx=0 (start bit) -> DATA, bit counter cleared.
  - bit_en & rx=1 -> stay IDLE.
- DATA:
  - Each bit_en shifts rx into the shift register at the MSB end, right-shifting, so the first bit lands in bit 0 after DATA_W shifts.
  - The counter increments per bit; the DATA_W-th bit -> PARITY.
- PARITY: on bit_en, capture rx as the parity bit -> STOP.
- STOP: on bit_en -> IDLE. On this same edge:
  - data_out <= shift register.
  - parity_err <= ~^{data, parity_bit}, i.e. the total count of ones must be odd.
  - frame_err <= ~rx.
  - data_valid <= 1.
- Latency: data_valid is high for exactly the one cycle after the stop-bit sampling edge.
- data_out and flags hold until the next frame completes. They are not cleared by data_valid falling.
- A frame with frame_err=1 still delivers data_out and parity_err.
- err_count:
  - Increments by exactly 1 on the STOP edge when parity_err or frame_err would be set; a frame with both errors counts once.
  - Saturates at 2^CNT_W-1 with no wrap.
- clr_count=1 zeroes err_count on that edge. It wins over a simultaneous increment, so the result is 0.
- Back-to-back frames: the start bit may arrive on the bit_en immediately after the stop bit. There are no dead cycles.
- busy = (state != IDLE), decoded combinationally from the state register.
- No glitch filtering or oversampling; the strobe source owns bit centring.

Decomposition:
- Package odd_parity_pkg holds:
  - the state enum (IDLE, DATA, PARITY, STOP);
  - a localparam for bit-counter width, $clog2(DATA_W+1);
  - a function odd_parity_ok(data, p) returning ^{data,p}. The transmit side shares it for generation.
- One sub-module is natural: odd_parity_check, a combinational checker (data, parity bit -> ok). It is reused by future parallel checkers.
- FSM, shift register and counter stay in the top module.

Test Plan:
1. DATA_W=8: send 0 | 0xA5 LSB-first | p=1 | 1 with bit_en every 4th cycle -> data_out=0xA5, data_valid pulses once, parity_err=0, frame_err=0, err_count=0.
2. Send 0x07 with p=1 (four ones total) -> parity_err=1, err_count=1. Then 0x07 with p=0 -> parity_err=0, err_count stays 1.
3. Send 0x3C, p=1, stop bit 0 -> frame_err=1, parity_err=0, data_out=0x3C, err_count+1.
4. Assert rst_n=0 after 4 data bits, release, then send a clean 0x5A frame -> no data_valid during the aborted frame, outputs all 0 after reset, then data_out=0x5A.
5. CNT_W=2: send 5 bad-parity frames -> err_count 1,2,3,3,3. Assert clr_count on the same edge as a 6th bad frame's stop -> err_count=0.
6. Back-to-back: 0x01 (p=0) then 0xFF (p=1) with the second start bit on the next bit_en after the first stop, with bit_en gaps of 1 and 7 cycles -> two data_valid pulses, data_out 0x01 then 0xFF, no errors.
